// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter using reverse double-dabble.
// Each CONVERT cycle shifts the combined BCD/binary register right by one bit.
// After the shift, every BCD digit that is >= 8 has 3 subtracted from it.
// A start that carries a non-decimal digit skips the conversion. It reports
// invalid with a zero result in the very next cycle.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  invalid
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = 2 * BCD_W;
    localparam int CNT_W = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SR_W-1:0]     sreg_q, sreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                inv_q, inv_d;
    logic [SR_W-1:0]     sreg_step;
    logic                bad_digit;

    // True when any 4-bit digit of the packed BCD value exceeds 9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then correct each BCD digit.
    // The correction only applies to digits >= 8, so it can never underflow.
    function automatic logic [SR_W-1:0] shift_correct(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] r;
        logic [3:0]      d;
        r = s >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = r[BCD_W + 4*i +: 4];
            if (d >= 4'd8) begin
                r[BCD_W + 4*i +: 4] = d - 4'd3;
            end
        end
        return r;
    endfunction

    // Datapath helpers: the next shift step and the validity check of the input.
    always_comb begin
        sreg_step = shift_correct(sreg_q);
        bad_digit = has_bad_digit(bcd_in);
    end

    // Next-state logic. Start is accepted in IDLE and DONE only.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (bad_digit) begin
                        bin_d   = '0;
                        inv_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sreg_d  = {bcd_in, {BCD_W{1'b0}}};
                        inv_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_CONVERT;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CONVERT: begin
                sreg_d = sreg_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    bin_d   = sreg_step[BIN_W-1:0];
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything and takes priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            inv_q   <= inv_d;
        end
    end

    assign busy    = (state_q == S_CONVERT);
    assign done    = (state_q == S_DONE);
    assign bin_out = bin_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed testbench for bcd2bin_seq (DIGITS=3, BIN_W=10).
module tb_bcd2bin_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        invalid;

    int checks;
    int failures;

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and wait (bounded) for done.
    task automatic convert(input string tag, input logic [11:0] bcd,
                           input logic [9:0] exp_bin, input logic exp_inv,
                           input int exp_lat);
        int lat;
        int nbusy;
        bcd_in = bcd;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        nbusy  = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_bin"}, bin_out, exp_bin);
        check({tag, "_inv"}, invalid, exp_inv);
        check({tag, "_busycyc"}, nbusy, (exp_lat == 13) ? 12 : 0);
        step();
        check({tag, "_done_low"}, done, 0);
        check({tag, "_held_bin"}, bin_out, exp_bin);
    endtask

    initial begin
        int lat;
        int ndone;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bcd_in   = 12'h000;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin_out, 0);
        check("rst_inv", invalid, 0);

        // Basic conversions
        convert("max999", 12'h999, 10'd999, 1'b0, 13);
        convert("zero",   12'h000, 10'd0,   1'b0, 13);
        convert("v409",   12'h409, 10'd409, 1'b0, 13);
        convert("v128",   12'h128, 10'd128, 1'b0, 13);
        convert("v080",   12'h080, 10'd80,  1'b0, 13);

        // Invalid digits in different positions
        convert("inv1A3", 12'h1A3, 10'd0,   1'b1, 1);
        convert("v050",   12'h050, 10'd50,  1'b0, 13);
        convert("inv90B", 12'h90B, 10'd0,   1'b1, 1);
        convert("invF00", 12'hF00, 10'd0,   1'b1, 1);

        // Start during CONVERT is ignored
        bcd_in = 12'h321;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        repeat (4) begin
            step();
            lat++;
        end
        bcd_in = 12'h777;
        start  = 1'b1;
        step();
        lat++;
        start  = 1'b0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        check("ign_lat", lat, 13);
        check("ign_bin", bin_out, 321);
        ndone = 0;
        repeat (20) begin
            step();
            if (done) ndone++;
        end
        check("ign_no2nd_done", ndone, 0);

        // Back-to-back with start held high
        bcd_in = 12'h100;
        start  = 1'b1;
        step();
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        check("b2b_lat1", lat, 13);
        check("b2b_bin1", bin_out, 100);
        bcd_in = 12'h255;
        step();
        lat++;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        start = 1'b0;
        check("b2b_lat2", lat, 26);
        check("b2b_bin2", bin_out, 255);
        step();
        check("b2b_done_low", done, 0);

        // Reset in the middle of a conversion
        bcd_in = 12'h999;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_bin", bin_out, 0);
        check("mid_rst_inv", invalid, 0);
        ndone = 0;
        repeat (20) begin
            step();
            if (done || busy) ndone++;
        end
        check("mid_rst_quiet", ndone, 0);
        convert("after_rst042", 12'h042, 10'd42, 1'b0, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
